button_conditioner: RTL and testbench

Front-end conditioner between the five raw board push-buttons and `game_logic`. It synchronises each button to `CLK`, debounces it, and produces single-cycle press pulses on `BtnU/BtnL/BtnC/BtnR/BtnD`, which `game_logic` consumes directly. Held direction buttons auto-repeat. The output bus is one-hot-or-zero, so `game_logic` never sees two commands in one cycle.

---
 rtl/chess_defs.sv | 40 ++++
 rtl/btn_debounce.sv | 156 +++++++++++++++
 rtl/button_conditioner.sv | 70 +++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_defs.sv
// Constants shared by the button front end and game_logic: button indices
// and the command priority order used when several presses coincide.
package chess_defs;

  localparam int NUM_BTNS = 5;

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_C = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_ARMING    = 2'd1,
    DB_PRESSED   = 2'd2,
    DB_RELEASING = 2'd3
  } db_state_e;

  // Keep only the highest-priority request, C > U > D > L > R; the rest are dropped.
  function automatic logic [NUM_BTNS-1:0] prio_pick(input logic [NUM_BTNS-1:0] req);
    logic [NUM_BTNS-1:0] gnt;
    gnt = '0;
    if (req[BTN_C]) begin
      gnt[BTN_C] = 1'b1;
    end else if (req[BTN_U]) begin
      gnt[BTN_U] = 1'b1;
    end else if (req[BTN_D]) begin
      gnt[BTN_D] = 1'b1;
    end else if (req[BTN_L]) begin
      gnt[BTN_L] = 1'b1;
    end else if (req[BTN_R]) begin
      gnt[BTN_R] = 1'b1;
    end else begin
      gnt = '0;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, debounce FSM and auto-repeat timer.
// Emits a registered single-cycle pulse on accepted presses and repeats.
module btn_debounce
  import chess_defs::*;
#(
  parameter int DB_COUNT      = 500000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 7500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW     = $clog2(DB_COUNT);
  localparam int RW_DLY = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int RW_PER = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int RW     = (RW_DLY > RW_PER) ? RW_DLY : RW_PER;

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RCNT_ONE = RW'(1);

  db_state_e       state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            rmode_q, rmode_d;
  logic            pulse_q, pulse_d;
  logic            level_s;

  assign level_s = sync_q[1];
  assign pulse   = pulse_q;

  // Synchroniser shift: newest raw sample enters bit 0.
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the stable-level counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (level_s) begin
          state_d = DB_ARMING;
        end else begin
          state_d = DB_IDLE;
        end
      end
      DB_ARMING: begin
        if (!level_s) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else begin
          state_d = DB_ARMING;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DB_PRESSED: begin
        cnt_d = '0;
        if (!level_s) begin
          state_d = DB_RELEASING;
        end else begin
          state_d = DB_PRESSED;
        end
      end
      DB_RELEASING: begin
        if (level_s) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = DB_RELEASING;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse generation: the accepted press, then delayed and periodic repeats.
  // Any cycle not spent staying in PRESSED clears the repeat timer and mode.
  always_comb begin
    pulse_d = 1'b0;
    rcnt_d  = '0;
    rmode_d = 1'b0;
    if ((state_q == DB_ARMING) && (state_d == DB_PRESSED)) begin
      pulse_d = 1'b1;
    end else if (REPEAT_EN && (state_q == DB_PRESSED) && (state_d == DB_PRESSED)) begin
      if (!rmode_q) begin
        if (rcnt_q == DLY_LAST) begin
          pulse_d = 1'b1;
          rmode_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rmode_d = 1'b0;
          rcnt_d  = rcnt_q + RCNT_ONE;
        end
      end else begin
        rmode_d = 1'b1;
        if (rcnt_q == PER_LAST) begin
          pulse_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + RCNT_ONE;
        end
      end
    end else begin
      pulse_d = 1'b0;
      rcnt_d  = '0;
      rmode_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      rmode_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rmode_q <= rmode_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five debounced button channels feeding a fixed-priority arbiter, so that
// game_logic sees at most one registered command pulse per cycle.
module button_conditioner
  import chess_defs::*;
#(
  parameter int DB_COUNT      = 500000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 7500000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic BtnU_raw,
  input  logic BtnL_raw,
  input  logic BtnC_raw,
  input  logic BtnR_raw,
  input  logic BtnD_raw,
  output logic BtnU,
  output logic BtnL,
  output logic BtnC,
  output logic BtnR,
  output logic BtnD
);

  logic [NUM_BTNS-1:0] raw_s;
  logic [NUM_BTNS-1:0] pulse_s;
  logic [NUM_BTNS-1:0] out_d, out_q;

  assign raw_s[BTN_U] = BtnU_raw;
  assign raw_s[BTN_L] = BtnL_raw;
  assign raw_s[BTN_C] = BtnC_raw;
  assign raw_s[BTN_R] = BtnR_raw;
  assign raw_s[BTN_D] = BtnD_raw;

  // Centre is a confirm button, so it never auto-repeats.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DB_COUNT      (DB_COUNT),
      .REPEAT_EN     ((i == BTN_C) ? 1'b0 : REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_db (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .btn_raw (raw_s[i]),
      .pulse   (pulse_s[i])
    );
  end

  // Arbiter: forward only the winning pulse.
  always_comb begin
    out_d = prio_pick(pulse_s);
  end

  // Output register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign BtnU = out_q[BTN_U];
  assign BtnL = out_q[BTN_L];
  assign BtnC = out_q[BTN_C];
  assign BtnR = out_q[BTN_R];
  assign BtnD = out_q[BTN_D];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed button scenarios plus random button activity,
// compared cycle by cycle against a run-length based reference model.
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam logic [4:0] B_U = 5'b00001;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_C = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_D = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n_r = 1'b0;
  logic [4:0] raw_r = 5'b00000;
  logic       u_o, l_o, c_o, r_o, d_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  logic [4:0] m_s1 = 5'b0, m_s2 = 5'b0, m_pulse = 5'b0, m_out = 5'b0;
  int  hi_run[5], lo_run[5], age[5];
  bit  held[5];

  // observation log
  logic [4:0] bus_obs = 5'b0, bus_prev = 5'b0;
  int  npulse[5];
  int  wq[$];
  int  watch_b = 0;
  int  start_c = 0;

  always #10 clk = ~clk;

  button_conditioner #(
    .DB_COUNT(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(clk), .RESET_N(rst_n_r),
    .BtnU_raw(raw_r[0]), .BtnL_raw(raw_r[1]), .BtnC_raw(raw_r[2]),
    .BtnR_raw(raw_r[3]), .BtnD_raw(raw_r[4]),
    .BtnU(u_o), .BtnL(l_o), .BtnC(c_o), .BtnR(r_o), .BtnD(d_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_pick(input logic [4:0] p);
    int order[5] = '{2, 0, 4, 1, 3};
    logic [4:0] g = 5'b0;
    for (int k = 0; k < 5; k++) begin
      if (p[order[k]]) begin
        g[order[k]] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  task automatic model_clear();
    m_s1 = 5'b0; m_s2 = 5'b0; m_pulse = 5'b0; m_out = 5'b0;
    for (int b = 0; b < 5; b++) begin
      hi_run[b] = 0; lo_run[b] = 0; age[b] = -1; held[b] = 1'b0;
    end
  endtask

  // One clock edge of the reference: a press is accepted once the synced level has
  // been high for DB+1 consecutive edges; release completes after DB+1 low edges.
  // Repeats fire RD edges after (re)entering the pressed level, then every RP.
  task automatic model_edge(input logic [4:0] raw, input logic rn);
    logic [4:0] np;
    logic s;
    if (!rn) begin
      model_clear();
      return;
    end
    m_out = ref_pick(m_pulse);
    np = 5'b0;
    for (int b = 0; b < 5; b++) begin
      s = m_s2[b];
      if (s) begin hi_run[b]++; lo_run[b] = 0; end
      else   begin lo_run[b]++; hi_run[b] = 0; end
      if (!held[b]) begin
        if (hi_run[b] == DB + 1) begin
          held[b] = 1'b1; np[b] = 1'b1; age[b] = 0;
        end
      end else if (s) begin
        if (age[b] < 0) age[b] = 0;
        else begin
          age[b]++;
          if (b != 2 && age[b] >= RD && ((age[b] - RD) % RP) == 0) np[b] = 1'b1;
        end
      end else begin
        age[b] = -1;
        if (lo_run[b] == DB + 1) held[b] = 1'b0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_pulse = np;
  endtask

  task automatic step(input logic [4:0] raw, input logic rn);
    raw_r = raw;
    rst_n_r = rn;
    @(posedge clk);
    model_edge(raw, rn);
    cyc++;
    @(negedge clk);
    bus_obs = {d_o, r_o, c_o, l_o, u_o};
    check_val("bus", {27'd0, bus_obs}, {27'd0, m_out});
    check_val("onehot0", {31'd0, $onehot0(bus_obs)}, 32'd1);
    check_val("no_back_to_back", {27'd0, bus_obs & bus_prev}, 32'd0);
    bus_prev = bus_obs;
    for (int b = 0; b < 5; b++) if (bus_obs[b]) npulse[b]++;
    if (bus_obs[watch_b]) wq.push_back(cyc);
  endtask

  task automatic run(input logic [4:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b1);
  endtask

  task automatic clear_log(input int wb);
    for (int b = 0; b < 5; b++) npulse[b] = 0;
    wq.delete();
    watch_b = wb;
    start_c = cyc + 1;
  endtask

  initial begin
    int exp_off[6] = '{0, 20, 28, 36, 44, 52};
    logic [4:0] rnd;
    model_clear();
    step(5'b0, 1'b0);
    step(5'b0, 1'b0);
    check_val("reset_bus", {27'd0, bus_obs}, 32'd0);
    run(5'b0, 6);

    // held U with release: press at +7, one repeat 20 later
    clear_log(0);
    run(B_U, 30);
    run(5'b0, 12);
    check_val("u_count", wq.size(), 32'd2);
    if (wq.size() >= 2) begin
      check_val("u_first", wq[0] - start_c, 32'd7);
      check_val("u_repeat", wq[1] - wq[0], 32'd20);
    end

    // short L glitches
    clear_log(1);
    run(B_L, 3); run(5'b0, 1); run(B_L, 2); run(5'b0, 1); run(B_L, 2);
    run(5'b0, 12);
    check_val("l_glitch", npulse[1], 32'd0);

    // long C hold, bouncy release, then a clean press
    clear_log(2);
    run(B_C, 100);
    for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 5'b0 : B_C, 1'b1);
    run(5'b0, 12);
    check_val("c_hold_count", npulse[2], 32'd1);
    clear_log(2);
    run(B_C, 20);
    run(5'b0, 12);
    check_val("c_repress_count", npulse[2], 32'd1);
    if (wq.size() >= 1) check_val("c_repress_first", wq[0] - start_c, 32'd7);

    // C and R together: C wins, R dropped
    clear_log(3);
    run(B_C | B_R, 15);
    run(5'b0, 12);
    check_val("cr_c_count", npulse[2], 32'd1);
    check_val("cr_r_count", npulse[3], 32'd0);

    // reset while D is held
    run(B_D, 10);
    step(B_D, 1'b0);
    check_val("rst_mid_bus", {27'd0, bus_obs}, 32'd0);
    clear_log(4);
    run(B_D, 12);
    run(5'b0, 12);
    check_val("d_after_rst_count", npulse[4], 32'd1);
    if (wq.size() >= 1) check_val("d_after_rst_first", wq[0] - start_c, 32'd7);

    // R held 60 cycles: press plus five repeats
    clear_log(3);
    run(B_R, 60);
    run(5'b0, 12);
    check_val("r_count", wq.size(), 32'd6);
    check_val("r_first", (wq.size() > 0) ? wq[0] - start_c : -1, 32'd7);
    if (wq.size() == 6)
      for (int k = 0; k < 6; k++) check_val("r_offset", wq[k] - wq[0], exp_off[k]);

    // random button activity with occasional resets
    rnd = 5'b0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 9) == 0) rnd[b] = ~rnd[b];
      step(rnd, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end
    run(5'b0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
